// File: rtl/led_pkg.sv
// Shared types and constants for the LED flash sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [2:0] LED_OFF = 3'b111;

  // Phase lengths of zero ticks are promoted to one tick.
  function automatic logic [7:0] min_one(input logic [7:0] ticks);
    return (ticks == 8'd0) ? 8'd1 : ticks;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
module tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  // A held clear keeps the count at zero, so no tick can appear while cleared.
  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// RGB flash sequencer: accepts one flash command, then alternates ON/OFF phases
// timed in prescaler ticks until the flash count is reached or abort arrives.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 24000000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_color,
  input  logic [7:0] cmd_on,
  input  logic [7:0] cmd_off,
  input  logic [3:0] cmd_count,
  input  logic       abort,
  output logic [2:0] led_n,
  output logic       busy,
  output logic       done
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;

  state_t     state_reg, state_next;
  logic [2:0] color_reg;
  logic [7:0] on_reg, off_reg;
  logic [3:0] count_reg;
  logic [3:0] flash_reg;
  logic [7:0] tcnt_reg;
  logic [2:0] led_n_reg, led_next;
  logic       done_reg, done_next;

  logic       tick;
  logic       accept;
  logic       expire;
  logic       last_flash;
  logic [7:0] phase_last;
  logic [3:0] flash_inc;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_reg == IDLE),
    .tick (tick)
  );

  assign cmd_ready  = (state_reg == IDLE) && !abort;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state_reg != IDLE);
  assign phase_last = ((state_reg == ON) ? min_one(on_reg) : min_one(off_reg)) - 8'd1;
  assign expire     = tick && (tcnt_reg == phase_last);
  assign flash_inc  = flash_reg + 4'd1;
  // count==0 never matches, so the counter just wraps in endless mode.
  assign last_flash = (count_reg != 4'd0) && (flash_inc == count_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = ON;
      ON: begin
        if (abort)       state_next = IDLE;
        else if (expire) state_next = OFF;
      end
      OFF: begin
        if (abort)       state_next = IDLE;
        else if (expire) state_next = last_flash ? IDLE : ON;
      end
      default: state_next = IDLE;
    endcase
  end

  // LED drive follows the next state so led_n changes on the same edge as the FSM.
  always_comb begin
    led_next  = LED_OFF;
    done_next = 1'b0;
    if (state_next == ON) begin
      led_next = accept ? ~cmd_color : ~color_reg;
    end
    if (state_reg == OFF && !abort && expire && last_flash) begin
      done_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_n_reg <= LED_OFF;
      done_reg  <= 1'b0;
    end else begin
      led_n_reg <= led_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_reg <= '0;
      on_reg    <= '0;
      off_reg   <= '0;
      count_reg <= '0;
      flash_reg <= '0;
      tcnt_reg  <= '0;
    end else if (accept) begin
      color_reg <= cmd_color;
      on_reg    <= cmd_on;
      off_reg   <= cmd_off;
      count_reg <= cmd_count;
      flash_reg <= '0;
      tcnt_reg  <= '0;
    end else if (state_reg != IDLE) begin
      if (expire) begin
        tcnt_reg <= '0;
        if (state_reg == OFF) flash_reg <= flash_inc;
      end else if (tick) begin
        tcnt_reg <= tcnt_reg + 8'd1;
      end
    end
  end

  assign led_n = led_n_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized and directed checks of led_seq_ctrl against a timeline model built from phase lengths.
module tb_led_seq_ctrl;

  localparam int CLK_HZ   = 1000;
  localparam int TICK_HZ  = 100;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_color = '0;
  logic [7:0] cmd_on = '0;
  logic [7:0] cmd_off = '0;
  logic [3:0] cmd_count = '0;
  logic       abort = 1'b0;
  logic [2:0] led_n;
  logic       busy;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;

  led_seq_ctrl #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_color(cmd_color),
    .cmd_on   (cmd_on),
    .cmd_off  (cmd_off),
    .cmd_count(cmd_count),
    .abort    (abort),
    .led_n    (led_n),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour is a flat per-cycle LED timeline: each flash is on_len cycles of
  // ~color then off_len cycles dark; busy while the timeline lasts, done one cycle after.
  task automatic run_cmd(input string name, input logic [2:0] col, input logic [7:0] on_t,
                         input logic [7:0] off_t, input logic [3:0] cnt,
                         input int abort_at, input bit perturb);
    logic [2:0] q[$];
    int onl, offl, n_flash, len;
    bit ended;
    onl  = ((on_t == 0) ? 1 : int'(on_t)) * TICK_DIV;
    offl = ((off_t == 0) ? 1 : int'(off_t)) * TICK_DIV;
    n_flash = (cnt == 0) ? (abort_at / (onl + offl) + 1) : int'(cnt);
    for (int f = 0; f < n_flash; f++) begin
      for (int i = 0; i < onl; i++) q.push_back(~col);
      for (int i = 0; i < offl; i++) q.push_back(3'b111);
    end
    len = q.size();

    @(negedge clk);
    check({name, " ready_before"}, cmd_ready, 1);
    cmd_color = col; cmd_on = on_t; cmd_off = off_t; cmd_count = cnt;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ended = 0;
    for (int c = 1; !ended; c++) begin
      if (abort_at > 0 && c == abort_at + 1) begin
        abort = 1'b0;
        check($sformatf("%s c%0d abort_led", name, c), led_n, 3'b111);
        check($sformatf("%s c%0d abort_busy", name, c), busy, 0);
        check($sformatf("%s c%0d abort_done", name, c), done, 0);
        ended = 1;
      end else if (c <= len) begin
        check($sformatf("%s c%0d led", name, c), led_n, q[c-1]);
        check($sformatf("%s c%0d busy", name, c), busy, 1);
        check($sformatf("%s c%0d done", name, c), done, 0);
        check($sformatf("%s c%0d ready", name, c), cmd_ready, 0);
      end else begin
        check($sformatf("%s c%0d end_done", name, c), done, 1);
        check($sformatf("%s c%0d end_busy", name, c), busy, 0);
        check($sformatf("%s c%0d end_led", name, c), led_n, 3'b111);
        @(negedge clk);
        check($sformatf("%s c%0d done_clear", name, c + 1), done, 0);
        ended = 1;
      end
      if (!ended) begin
        if (perturb) begin
          cmd_color = 3'($urandom); cmd_on = 8'($urandom);
          cmd_off = 8'($urandom); cmd_count = 4'($urandom);
        end
        abort = (c == abort_at);
        @(negedge clk);
      end
    end
    $display("[TB] %s: color=%b on=%0d off=%0d count=%0d abort_at=%0d len=%0d", name, col, on_t,
             off_t, cnt, abort_at, len);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("in_reset led_n", led_n, 3'b111);
    check("in_reset done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset led_n", led_n, 3'b111);
    check("post_reset busy", busy, 0);
    check("post_reset ready", cmd_ready, 1);
    check("post_reset done", done, 0);
    $display("[TB] reset checked");

    run_cmd("finite", 3'b100, 8'd2, 8'd3, 4'd2, 0, 0);
    run_cmd("zero_fields", 3'b011, 8'd0, 8'd0, 4'd1, 0, 0);
    run_cmd("abort57", 3'b010, 8'd2, 8'd1, 4'd0, 57, 0);
    run_cmd("after_abort", 3'b001, 8'd1, 8'd1, 4'd1, 0, 0);
    run_cmd("abort_on_expiry", 3'b110, 8'd1, 8'd2, 4'd0, 10, 0);
    run_cmd("dark", 3'b000, 8'd1, 8'd2, 4'd2, 0, 0);
    run_cmd("perturb", 3'b101, 8'd3, 8'd1, 4'd2, 0, 1);

    // abort held in IDLE blocks acceptance
    @(negedge clk);
    abort = 1'b1; cmd_valid = 1'b1; cmd_color = 3'b111; cmd_on = 8'd1; cmd_off = 8'd1; cmd_count = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("idle_abort c%0d ready", i), cmd_ready, 0);
      check($sformatf("idle_abort c%0d busy", i), busy, 0);
      check($sformatf("idle_abort c%0d led", i), led_n, 3'b111);
    end
    cmd_valid = 1'b0; abort = 1'b0;
    $display("[TB] idle abort collision checked");

    // Reset asserted while ON
    @(negedge clk);
    cmd_color = 3'b010; cmd_on = 8'd5; cmd_off = 8'd1; cmd_count = 4'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_reset pre led", led_n, 3'b101);
    rst_n = 1'b0;
    #1;
    check("mid_reset led", led_n, 3'b111);
    check("mid_reset busy", busy, 0);
    check("mid_reset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_mid_reset c%0d done", i), done, 0);
      check($sformatf("post_mid_reset c%0d busy", i), busy, 0);
    end
    $display("[TB] mid-sequence reset checked");

    // Randomized commands; endless ones are aborted somewhere inside their timeline
    for (int t = 0; t < 10; t++) begin
      logic [2:0] col;
      logic [7:0] on_t, off_t;
      logic [3:0] cnt;
      int ab;
      col   = 3'($urandom);
      on_t  = 8'($urandom_range(0, 3));
      off_t = 8'($urandom_range(0, 3));
      cnt   = 4'($urandom_range(0, 3));
      ab    = (cnt == 0) ? int'($urandom_range(1, 150)) : 0;
      run_cmd($sformatf("rand%0d", t), col, on_t, off_t, cnt, ab, ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 24000000: input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100: timebase tick rate in Hz; TICK_DIV = CLK_HZ/TICK_HZ, which SHALL be an integer of at least 2.
REQ-003 Port clk  in  1: single clock; all state is updated on its rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 Port cmd_valid  in  1: a flash command is presented.
REQ-006 Port cmd_ready  out  1: the block accepts the presented command this cycle.
REQ-007 Port cmd_color  in  3: {r,g,b} enable mask for the command.
REQ-008 Port cmd_on  in  8: on-time in ticks; 0 is treated as 1.
REQ-009 Port cmd_off  in  8: off-time in ticks; 0 is treated as 1.
REQ-010 Port cmd_count  in  4: number of flashes; 0 means repeat until abort.
REQ-011 Port abort  in  1: terminate the active sequence.
REQ-012 Port led_n  out  3: {r,g,b} LED drive, active-low, registered.
REQ-013 Port busy  out  1: high in any state other than IDLE.
REQ-014 Port done  out  1: one-cycle pulse when a finite sequence completes.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ON and OFF.
REQ-016 cmd_ready SHALL equal (state==IDLE) && !abort; a command is accepted when cmd_valid && cmd_ready.
REQ-017 On accept, the block SHALL latch color, on, off and count, clear the prescaler and flash counter, and enter ON at that clock edge.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 and wrap; a tick is asserted on the cycle it reads TICK_DIV-1.
REQ-019 The prescaler SHALL be held cleared in IDLE.
REQ-020 In ON, led_n SHALL equal ~color; in IDLE and OFF, led_n SHALL be 3'b111.
REQ-021 ON SHALL last exactly max(on,1)*TICK_DIV cycles and then go to OFF.
REQ-022 OFF SHALL last exactly max(off,1)*TICK_DIV cycles; on leaving OFF the flash counter SHALL increment.
REQ-023 Leaving OFF, if count!=0 and the incremented flash counter equals count, the FSM SHALL go to IDLE and pulse done in the first IDLE cycle; otherwise it SHALL go to ON.
REQ-024 With count==0 the FSM SHALL cycle ON and OFF indefinitely, and the 4-bit flash counter SHALL wrap harmlessly.
REQ-025 abort asserted in ON or OFF SHALL force IDLE at the next edge, with led_n=3'b111 and no done pulse.
REQ-026 abort asserted in IDLE SHALL block acceptance (REQ-016) and have no other effect.
REQ-027 abort SHALL take priority over an ON/OFF expiry in the same cycle.
REQ-028 A color of 3'b000 SHALL still run the full timing sequence, with all LEDs dark.
REQ-029 Command inputs SHALL be ignored outside the accept cycle; changing them mid-sequence has no effect.

Reset
REQ-030 While rst_n=0: state=IDLE, prescaler=0, flash counter=0, latched fields=0, led_n=3'b111, done=0.
REQ-031 After reset, busy=0 and cmd_ready=1 (when abort=0).
REQ-032 Reset asserted mid-sequence SHALL terminate it immediately, asynchronously, with no done pulse.

Structure
REQ-033 A shared package led_pkg SHALL hold the state enum (IDLE, ON, OFF) and the constant LED_OFF=3'b111.
REQ-034 The prescaler SHALL be the single sub-module tick_gen, with ports clk, rst_n, clr and tick, parameterised by TICK_DIV.

Verification (CLK_HZ=1000, TICK_HZ=100, so TICK_DIV=10)
REQ-035 Reset check: reset, then release -> led_n=111, busy=0, cmd_ready=1, done=0.
REQ-036 Finite sequence: color=100, on=2, off=3, count=2 -> led_n=011 for 20 cycles, 111 for 30, 011 for 20, 111 for 30; then IDLE with one done pulse; total busy 100 cycles.
REQ-037 Zero-field handling: on=0, off=0, count=1 -> 10 cycles on, 10 cycles off, done; cmd_ready low while busy.
REQ-038 Abort timing: count=0, abort pulsed at cycle 57 after accept -> led_n=111 and busy=0 at the next edge, no done; a new command is accepted afterwards.
REQ-039 Collisions: abort held high in IDLE with cmd_valid=1 -> no accept. abort coincident with an ON expiry -> IDLE.
REQ-040 Reset mid-operation: rst_n low during ON -> led_n=111 immediately, no done pulse. Mid-sequence changes to the cmd_* inputs leave the timing unchanged.
